reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Sequences per-domain reset release after a system reset. Sits downstream of the system reset generator, in the same clock domain as that generator's `user_clk`. While the system reset is high, every domain reset is held asserted. Once it falls, domains are released one at a time in index order: each release waits for that domain's ready acknowledgement or a timeout before the next domain is released.

## Interface
Parameters:
- `Domain_Count`, 4: number of sequenced reset domains. Range 2..16.
- `Stage_Gap_Cycles`, 16: enabled cycles spent in GAP before each domain release. Must be ≥1.
- `Ready_Timeout_Cycles`, 4096: enabled cycles to wait for `domain_ready[k]` before declaring a fault. Must be ≥1.

Ports:
- `clk`  in  1: system clock. Single clock domain.
- `sync_rst`  in  1: synchronous, active-high reset.
- `clk_en`  in  1: advances counters and the FSM. Does not gate `sync_rst` or `sys_rst_in` reassertion.
- `sys_rst_in`  in  1: level system reset from the reset generator, already synchronous to `clk`. High means hold everything in reset.
- `domain_ready`  in  `Domain_Count`: per-domain "came out of reset" acknowledgement. Level; sampled only in WAIT_READY.
- `domain_rst`  out  `Domain_Count`: per-domain synchronous active-high reset. Registered.
- `all_released`  out  1: high in DONE only. Registered.
- `timeout_fault`  out  1: sticky; set by any ready timeout.
- `fault_domain`  out  `max(1,$clog2(Domain_Count))`: index of the first domain that timed out.

## Operation
- FSM states: ASSERT_ALL, GAP, WAIT_READY, DONE.
  - Also keeps a domain index `idx` and one shared counter `cnt`.
  - `cnt` width is `$clog2(max(Stage_Gap_Cycles, Ready_Timeout_Cycles)+1)`.
- Values on `sync_rst` (next edge), which are also the reset value of every output:
  - state = ASSERT_ALL, `idx`=0, `cnt`=0
  - `domain_rst` = all ones
  - `all_released`=0, `timeout_fault`=0, `fault_domain`=0
- ASSERT_ALL: all `domain_rst` bits are 1. When `clk_en` is high and `sys_rst_in` is 0, go to GAP with `cnt`=0 and `idx`=0. The fault registers are cleared on this same transition.
- GAP: `cnt` increments on each enabled cycle. On the enabled cycle with `cnt`==`Stage_Gap_Cycles-1`:
  - clear `domain_rst[idx]`;
  - go to WAIT_READY with `cnt`=0.
- WAIT_READY, per enabled cycle:
  - If `domain_ready[idx]`==1, advance.
  - Else if `cnt`==`Ready_Timeout_Cycles-1`, advance. If `timeout_fault` is not already set, first set `timeout_fault` and load `fault_domain`=`idx`.
  - Else `cnt`++.
  - Ready wins over timeout in the same cycle (no fault).
- Advance:
  - If `idx`==`Domain_Count-1`, go to DONE and set `all_released`=1.
  - Otherwise `idx`++, `cnt`=0, go to GAP.
  - A timed-out domain stays released (`domain_rst` stays 0).
- DONE: hold all outputs. `domain_ready` is ignored.
- Reassertion: `sys_rst_in`==1 in any state, with any `clk_en` value, takes effect at the next edge:
  - all `domain_rst` = 1, `all_released`=0;
  - state ASSERT_ALL, `idx`=0, `cnt`=0;
  - fault registers are preserved until the next release begins.
- Priority: `sync_rst` > `sys_rst_in` > FSM progress.
- Release order is strictly ascending index. At most one domain transitions per edge.

## Timing
- With `clk_en` held high, `sys_rst_in` is first sampled 0 at edge E0:
  - `domain_rst[0]` falls at edge E0+`Stage_Gap_Cycles`;
  - WAIT_READY for domain 0 begins on the following cycle.
- Domain k+1 release: `domain_ready[k]` sampled 1 at edge Ek → `domain_rst[k+1]` falls at Ek+`Stage_Gap_Cycles`.
- Timeout: WAIT_READY entered at edge W, ready never seen → advance (and fault set) at edge W+`Ready_Timeout_Cycles`.
- `all_released` rises on the same edge that consumes the last ready or timeout.
- While `clk_en`=0, all counters and states freeze; only `sync_rst` and `sys_rst_in` act.
- `sys_rst_in` reassertion latency: 1 edge to all `domain_rst`=1.
- No combinational path from any input to any output.

## Test plan
- Test 1, `sync_rst` then idle. Stimulus: `sync_rst` pulse with `sys_rst_in`=1 held. Required: `domain_rst`=4'hF, `all_released`=0, `timeout_fault`=0 throughout.
- Test 2, normal sequence. Stimulus: `Domain_Count`=4, `Stage_Gap_Cycles`=16; drop `sys_rst_in`; each `domain_ready[k]` asserts 3 cycles after `domain_rst[k]` falls. Required:
  - `domain_rst` steps F→E→C→8→0;
  - 16-cycle gaps between each ready sample and the next release;
  - `all_released`=1 on the edge that samples `domain_ready[3]`.
- Test 3, timeout. Stimulus: `Ready_Timeout_Cycles`=8; domain 1 never asserts ready. Required:
  - `timeout_fault`=1 and `fault_domain`=1, 8 cycles after WAIT_READY entry;
  - the sequence continues to DONE;
  - a later timeout on domain 3 leaves `fault_domain`=1.
- Test 4, ready-versus-timeout tie. Stimulus: ready arrives exactly on cycle `cnt`==`Ready_Timeout_Cycles-1`. Required: advance occurs with `timeout_fault`=0.
- Test 5, mid-sequence reassert. Stimulus: `sys_rst_in` pulses for 1 cycle while in WAIT_READY for domain 2 with `clk_en`=0. Required:
  - next edge: `domain_rst`=F, `all_released`=0;
  - fault retained until re-release;
  - a full sequence restarts from domain 0.
- Test 6, `clk_en` stall. Stimulus: toggle `clk_en` 1-in-3 during GAP. Required: release occurs after exactly 16 enabled cycles, i.e. 48 clocks.

Source files
------------

// File: rtl/reset_sequencer.sv
// Per-domain reset release sequencer: holds every domain in reset while the
// system reset is high, then releases domains one by one in ascending order.
//
//   state         | meaning
//   --------------+------------------------------------------------------
//   ST_ASSERT_ALL | all domain resets asserted, waiting for sys_rst_in low
//   ST_GAP        | settling gap before releasing domain idx
//   ST_WAIT_READY | domain idx released, waiting for its ready or timeout
//   ST_DONE       | every domain released, outputs held
module reset_sequencer #(
    parameter int Domain_Count         = 4,
    parameter int Stage_Gap_Cycles     = 16,
    parameter int Ready_Timeout_Cycles = 4096
) (
    input  logic                    i_clk,
    input  logic                    i_sync_rst,
    input  logic                    i_clk_en,
    input  logic                    i_sys_rst_in,
    input  logic [Domain_Count-1:0] i_domain_ready,
    output logic [Domain_Count-1:0] o_domain_rst,
    output logic                    o_all_released,
    output logic                    o_timeout_fault,
    output logic [((Domain_Count > 2) ? $clog2(Domain_Count) : 1)-1:0] o_fault_domain
);

    localparam int IdxW      = (Domain_Count > 2) ? $clog2(Domain_Count) : 1;
    localparam int MaxCycles = (Stage_Gap_Cycles > Ready_Timeout_Cycles) ?
                               Stage_Gap_Cycles : Ready_Timeout_Cycles;
    localparam int CntW      = $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0] GapLast = CntW'(Stage_Gap_Cycles - 1);
    localparam logic [CntW-1:0] TmoLast = CntW'(Ready_Timeout_Cycles - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(Domain_Count - 1);

    typedef enum logic [1:0] {
        ST_ASSERT_ALL = 2'd0,
        ST_GAP        = 2'd1,
        ST_WAIT_READY = 2'd2,
        ST_DONE       = 2'd3
    } state_t;

    state_t                  r_state;
    logic [IdxW-1:0]         r_idx;
    logic [CntW-1:0]         r_cnt;
    logic [Domain_Count-1:0] r_domain_rst;
    logic                    r_all_released;
    logic                    r_timeout_fault;
    logic [IdxW-1:0]         r_fault_domain;

    state_t                  w_state_nxt;
    logic [IdxW-1:0]         w_idx_nxt;
    logic [CntW-1:0]         w_cnt_nxt;
    logic [Domain_Count-1:0] w_domain_rst_nxt;
    logic                    w_all_released_nxt;
    logic                    w_timeout_fault_nxt;
    logic [IdxW-1:0]         w_fault_domain_nxt;

    logic w_gap_end;
    logic w_ready;
    logic w_tmo;
    logic w_advance;
    logic w_last;

    assign w_gap_end = (r_cnt == GapLast);
    assign w_ready   = i_domain_ready[r_idx];
    assign w_tmo     = (r_cnt == TmoLast);
    assign w_advance = w_ready | w_tmo;
    assign w_last    = (r_idx == IdxLast);

    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            r_state         <= ST_ASSERT_ALL;
            r_idx           <= '0;
            r_cnt           <= '0;
            r_domain_rst    <= '1;
            r_all_released  <= 1'b0;
            r_timeout_fault <= 1'b0;
            r_fault_domain  <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_idx           <= w_idx_nxt;
            r_cnt           <= w_cnt_nxt;
            r_domain_rst    <= w_domain_rst_nxt;
            r_all_released  <= w_all_released_nxt;
            r_timeout_fault <= w_timeout_fault_nxt;
            r_fault_domain  <= w_fault_domain_nxt;
        end
    end

    // System reset reassertion bypasses clk_en so a stalled sequencer still re-arms.
    always_comb begin
        w_state_nxt = r_state;
        if (i_sys_rst_in) begin
            w_state_nxt = ST_ASSERT_ALL;
        end else if (i_clk_en) begin
            case (r_state)
                ST_ASSERT_ALL: w_state_nxt = ST_GAP;
                ST_GAP:        if (w_gap_end) w_state_nxt = ST_WAIT_READY;
                ST_WAIT_READY: if (w_advance) w_state_nxt = w_last ? ST_DONE : ST_GAP;
                ST_DONE:       w_state_nxt = ST_DONE;
                default:       w_state_nxt = ST_ASSERT_ALL;
            endcase
        end
    end

    always_comb begin
        w_idx_nxt           = r_idx;
        w_cnt_nxt           = r_cnt;
        w_domain_rst_nxt    = r_domain_rst;
        w_all_released_nxt  = r_all_released;
        w_timeout_fault_nxt = r_timeout_fault;
        w_fault_domain_nxt  = r_fault_domain;
        if (i_sys_rst_in) begin
            // Fault registers survive reassertion so software can still read them.
            w_domain_rst_nxt   = '1;
            w_all_released_nxt = 1'b0;
            w_idx_nxt          = '0;
            w_cnt_nxt          = '0;
        end else if (i_clk_en) begin
            case (r_state)
                ST_ASSERT_ALL: begin
                    w_domain_rst_nxt    = '1;
                    w_idx_nxt           = '0;
                    w_cnt_nxt           = '0;
                    w_timeout_fault_nxt = 1'b0;
                    w_fault_domain_nxt  = '0;
                end
                ST_GAP: begin
                    if (w_gap_end) begin
                        w_domain_rst_nxt[r_idx] = 1'b0;
                        w_cnt_nxt               = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_WAIT_READY: begin
                    if (w_advance) begin
                        if (!w_ready && !r_timeout_fault) begin
                            w_timeout_fault_nxt = 1'b1;
                            w_fault_domain_nxt  = r_idx;
                        end
                        if (w_last) begin
                            w_all_released_nxt = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_domain_rst    = r_domain_rst;
    assign o_all_released  = r_all_released;
    assign o_timeout_fault = r_timeout_fault;
    assign o_fault_domain  = r_fault_domain;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: vector table for reset behaviour,
// cycle-exact hand sequences for release, timeout, tie, reassert and stall.
module tb_reset_sequencer;

    localparam int Domains = 4;
    localparam int Gap     = 16;
    localparam int Tmo     = 8;

    logic       clk;
    logic       sync_rst;
    logic       clk_en;
    logic       sys_rst_in;
    logic [3:0] domain_ready;
    logic [3:0] domain_rst;
    logic       all_released;
    logic       timeout_fault;
    logic [1:0] fault_domain;

    reset_sequencer #(
        .Domain_Count        (Domains),
        .Stage_Gap_Cycles    (Gap),
        .Ready_Timeout_Cycles(Tmo)
    ) dut (
        .i_clk         (clk),
        .i_sync_rst    (sync_rst),
        .i_clk_en      (clk_en),
        .i_sys_rst_in  (sys_rst_in),
        .i_domain_ready(domain_ready),
        .o_domain_rst  (domain_rst),
        .o_all_released(all_released),
        .o_timeout_fault(timeout_fault),
        .o_fault_domain(fault_domain)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] rst;
        logic       ar;
        logic       tf;
        logic [1:0] fd;
        string      nm;
    } exp_t;

    typedef struct {
        logic       srst;
        logic       sys;
        logic       en;
        logic [3:0] rdy;
        logic [3:0] e_rst;
        logic       e_ar;
        logic       e_tf;
        logic [1:0] e_fd;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic       exp_ar;
    logic       exp_tf;
    logic [1:0] exp_fd;

    // Drive one cycle of stimulus, queue the expectation, compare after the edge.
    task automatic step(input logic srst, input logic sys, input logic en,
                        input logic [3:0] rdy, input logic [3:0] e_rst,
                        input logic e_ar, input logic e_tf, input logic [1:0] e_fd,
                        input string nm);
        exp_t e;
        sync_rst     = srst;
        sys_rst_in   = sys;
        clk_en       = en;
        domain_ready = rdy;
        e.rst = e_rst;
        e.ar  = e_ar;
        e.tf  = e_tf;
        e.fd  = e_fd;
        e.nm  = nm;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        checks++;
        if (domain_rst !== e.rst || all_released !== e.ar ||
            timeout_fault !== e.tf || fault_domain !== e.fd) begin
            errors++;
            $display("FAIL %s: got rst=%h ar=%b tf=%b fd=%0d, want rst=%h ar=%b tf=%b fd=%0d",
                     e.nm, domain_rst, all_released, timeout_fault, fault_domain,
                     e.rst, e.ar, e.tf, e.fd);
        end
    endtask

    task automatic s(input logic sys, input logic en, input logic [3:0] rdy,
                     input logic [3:0] e_rst, input string nm);
        step(1'b0, sys, en, rdy, e_rst, exp_ar, exp_tf, exp_fd, nm);
    endtask

    task automatic reassert(input logic en);
        exp_ar = 1'b0;
        s(1'b1, en, 4'h0, 4'hF, "reassert");
    endtask

    // Full release from ASSERT_ALL; late = domains that never answer,
    // tie = domains whose ready lands on the last timeout cycle.
    task automatic run_seq(input logic [3:0] late, input logic [3:0] tie, input int stop_at);
        logic [3:0] rdy;
        logic [3:0] cur;
        rdy    = 4'h0;
        cur    = 4'hF;
        exp_ar = 1'b0;
        exp_tf = 1'b0;
        exp_fd = 2'd0;
        s(1'b0, 1'b1, rdy, cur, "release_start");
        for (int k = 0; k < Domains; k++) begin
            for (int i = 0; i < Gap - 1; i++) s(1'b0, 1'b1, rdy, cur, "gap_hold");
            cur[k] = 1'b0;
            s(1'b0, 1'b1, rdy, cur, "domain_release");
            if (k == stop_at) return;
            if (late[k]) begin
                for (int i = 0; i < Tmo - 1; i++) s(1'b0, 1'b1, rdy, cur, "wait_no_ready");
                if (!exp_tf) begin
                    exp_tf = 1'b1;
                    exp_fd = 2'(k);
                end
            end else if (tie[k]) begin
                for (int i = 0; i < Tmo - 1; i++) s(1'b0, 1'b1, rdy, cur, "wait_before_tie");
                rdy[k] = 1'b1;
            end else begin
                for (int i = 0; i < 2; i++) s(1'b0, 1'b1, rdy, cur, "wait_ready_delay");
                rdy[k] = 1'b1;
            end
            if (k == Domains - 1) exp_ar = 1'b1;
            s(1'b0, 1'b1, rdy, cur, "advance");
        end
        for (int i = 0; i < 3; i++) s(1'b0, 1'b1, 4'h0, 4'h0, "done_hold");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        vecs[0] = '{1'b1, 1'b1, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 2'd0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 2'd0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0};

        exp_ar = 1'b0;
        exp_tf = 1'b0;
        exp_fd = 2'd0;

        // Test 1: sync_rst and idle behaviour
        for (int i = 0; i < 8; i++)
            step(vecs[i].srst, vecs[i].sys, vecs[i].en, vecs[i].rdy,
                 vecs[i].e_rst, vecs[i].e_ar, vecs[i].e_tf, vecs[i].e_fd, "vector_table");

        // Test 2: normal release F->E->C->8->0
        run_seq(4'b0000, 4'b0000, 99);
        reassert(1'b1);

        // Test 3: domains 1 and 3 time out, first fault index kept
        run_seq(4'b1010, 4'b0000, 99);
        reassert(1'b1);
        s(1'b1, 1'b1, 4'h0, 4'hF, "fault_kept_in_assert");

        // Test 4: ready on the final timeout cycle wins
        run_seq(4'b0000, 4'b0100, 99);
        reassert(1'b0);

        // Test 5: reassert with clk_en low while waiting on domain 2
        run_seq(4'b0001, 4'b0000, 2);
        reassert(1'b0);
        for (int i = 0; i < 3; i++) s(1'b0, 1'b0, 4'h0, 4'hF, "frozen_fault_kept");
        run_seq(4'b0000, 4'b0000, 99);
        reassert(1'b1);

        // Test 6: clk_en 1-in-3 during GAP, then frozen timeout counter
        exp_tf = 1'b0;
        exp_fd = 2'd0;
        s(1'b0, 1'b1, 4'h0, 4'hF, "stall_release_start");
        for (int c = 1; c <= 3 * Gap; c++)
            s(1'b0, (c % 3) == 0, 4'h0, (c == 3 * Gap) ? 4'hE : 4'hF, "stall_gap");
        for (int i = 0; i < 20; i++) s(1'b0, 1'b0, 4'h0, 4'hE, "stall_wait_frozen");
        for (int i = 0; i < Tmo - 1; i++) s(1'b0, 1'b1, 4'h0, 4'hE, "stall_wait_count");
        exp_tf = 1'b1;
        exp_fd = 2'd0;
        s(1'b0, 1'b1, 4'h0, 4'hE, "stall_timeout");
        reassert(1'b1);

        // sync_rst clears the sticky fault
        exp_tf = 1'b0;
        exp_fd = 2'd0;
        step(1'b1, 1'b1, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0, "sync_rst_clears_fault");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
